// File: rtl/bound_flasher_pkg.sv
// Shared types and helpers for the bound flasher: sweep states, per-state
// target marks and the kickback-capable states.
package bound_flasher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP1,
    DN1,
    UP2,
    DN2,
    UP3,
    DN3
  } state_e;

  function automatic int unsigned target_of(input state_e      s,
                                            input int unsigned n_led,
                                            input int unsigned lo_mark,
                                            input int unsigned hi_mark,
                                            input int unsigned end_mark);
    case (s)
      UP1:     return n_led;
      DN1:     return lo_mark;
      UP2:     return hi_mark;
      UP3:     return end_mark;
      default: return 0;
    endcase
  endfunction

  // Down sweeps whose dwell tick can bounce back to the preceding up sweep.
  function automatic logic is_kick_state(input state_e s);
    return (s == DN1) || (s == DN2);
  endfunction

endpackage

// File: rtl/bound_flasher_gen_step_prescaler.sv
// Step-rate prescaler: emits a one-cycle tick every STEP_DIV enabled cycles;
// clear forces the count back to zero.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bound_flasher_gen.sv
// Parametrised bound flasher: thermometer LED bar sweeping a six-phase
// up/down pattern with kickback, a step prescaler and busy/level status.
module bound_flasher_gen
  import bound_flasher_pkg::*;
#(
  parameter int unsigned N_LED    = 16,
  parameter int unsigned LO_MARK  = 5,
  parameter int unsigned HI_MARK  = 11,
  parameter int unsigned END_MARK = 6,
  parameter int unsigned STEP_DIV = 1,
  localparam int unsigned LW      = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flick,
  output logic [N_LED-1:0] LED,
  output logic [LW-1:0]    level,
  output logic             busy
);

  if (N_LED < 4 || LO_MARK == 0 || LO_MARK >= HI_MARK || HI_MARK >= N_LED ||
      END_MARK == 0 || END_MARK > N_LED || STEP_DIV < 1) begin : g_bad_params
    $error("bound_flasher_gen: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    target;
  logic [N_LED-1:0] led_q, led_d;
  logic             busy_q;
  logic             idle;
  logic             tick;

  assign idle   = (state_q == IDLE);
  assign target = LW'(target_of(state_q, N_LED, LO_MARK, HI_MARK, END_MARK));

  step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (idle),
    .enable_i (!idle),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (idle) begin
      if (flick) begin
        state_d = UP1;
        level_d = '0;
      end
    end else if (tick) begin
      // DN2 can also bounce at the low mark, holding the level for that step.
      if (state_q == DN2 && level_q == LW'(LO_MARK) && flick) begin
        state_d = UP2;
      end else if (level_q == target) begin
        if (is_kick_state(state_q) && flick) begin
          state_d = (state_q == DN1) ? UP1 : UP2;
        end else begin
          unique case (state_q)
            UP1:     state_d = DN1;
            DN1:     state_d = UP2;
            UP2:     state_d = DN2;
            DN2:     state_d = UP3;
            UP3:     state_d = DN3;
            default: state_d = IDLE;
          endcase
        end
      end else if (level_q < target) begin
        level_d = level_q + LW'(1);
      end else begin
        level_d = level_q - LW'(1);
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      led_d[i] = (LW'(i) < level_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= led_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign LED   = led_q;
  assign level = level_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Scoreboard bench for bound_flasher_gen: three instances (default, slow
// prescaler, small bar) checked cycle by cycle against a phase-list model.
module tb_bound_flasher_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        flick_a, flick_b, flick_c;
  logic [15:0] led_a, led_b;
  logic [7:0]  led_c;
  logic [4:0]  lvl_a, lvl_b;
  logic [3:0]  lvl_c;
  logic        busy_a, busy_b, busy_c;

  bound_flasher_gen dut_a (
    .clk(clk), .reset(rst_a), .flick(flick_a), .LED(led_a), .level(lvl_a), .busy(busy_a)
  );

  bound_flasher_gen #(.STEP_DIV(4)) dut_b (
    .clk(clk), .reset(rst_b), .flick(flick_b), .LED(led_b), .level(lvl_b), .busy(busy_b)
  );

  bound_flasher_gen #(.N_LED(8), .LO_MARK(2), .HI_MARK(5), .END_MARK(3)) dut_c (
    .clk(clk), .reset(rst_c), .flick(flick_c), .LED(led_c), .level(lvl_c), .busy(busy_c)
  );

  int nled [3] = '{16, 16, 8};
  int lo   [3] = '{5, 5, 2};
  int hi   [3] = '{11, 11, 5};
  int endm [3] = '{6, 6, 3};
  int div  [3] = '{1, 4, 1};

  // Model: a run is the phase list [N, LO, HI, 0, END, 0]; kickback steps one phase back.
  bit m_active [3];
  int m_phase  [3];
  int m_lvl    [3];
  int m_pcnt   [3];

  typedef struct {
    int d;
    int lvl;
    bit busy;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int busy_cnt [3];

  function automatic int tgt(input int d, input int p);
    case (p)
      0:       return nled[d];
      1:       return lo[d];
      2:       return hi[d];
      4:       return endm[d];
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int d, input bit f);
    if (!m_active[d]) begin
      if (f) begin
        m_active[d] = 1'b1;
        m_phase[d]  = 0;
        m_lvl[d]    = 0;
        m_pcnt[d]   = 0;
      end
    end else if (m_pcnt[d] != div[d] - 1) begin
      m_pcnt[d]++;
    end else begin
      m_pcnt[d] = 0;
      if (m_phase[d] == 3 && m_lvl[d] == lo[d] && f) m_phase[d] = 2;
      else if (m_lvl[d] == tgt(d, m_phase[d])) begin
        if ((m_phase[d] == 1 || m_phase[d] == 3) && f) m_phase[d]--;
        else if (m_phase[d] == 5) m_active[d] = 1'b0;
        else m_phase[d]++;
      end else if (m_lvl[d] < tgt(d, m_phase[d])) m_lvl[d]++;
      else m_lvl[d]--;
    end
  endtask

  task automatic model_reset(input int d);
    m_active[d] = 1'b0;
    m_lvl[d]    = 0;
    m_pcnt[d]   = 0;
    m_phase[d]  = 0;
  endtask

  task automatic set_flick(input int d, input bit f);
    case (d)
      0:       flick_a = f;
      1:       flick_b = f;
      default: flick_c = f;
    endcase
  endtask

  task automatic push_exp(input int d);
    exp_t e;
    e.d    = d;
    e.lvl  = m_lvl[d];
    e.busy = m_active[d];
    q.push_back(e);
  endtask

  // One cycle: drive flick for the coming edge and queue the predicted result.
  task automatic step(input int d, input bit f);
    @(posedge clk);
    #2;
    set_flick(d, f);
    model_step(d, f);
    push_exp(d);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  function automatic bit pick_flick(input int d, input int mode, input bit kicked);
    case (mode)
      1:       return !kicked && m_phase[d] == 1 && m_lvl[d] == lo[d];
      2:       return !kicked && m_phase[d] == 3 && m_lvl[d] == lo[d];
      3:       return !kicked && m_phase[d] == 3 && m_lvl[d] == 0;
      4:       return (m_phase[d] == 0 && m_lvl[d] == 8) || (m_phase[d] == 5 && m_lvl[d] == 3);
      5:       return ($urandom_range(0, 7) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run(input int d, input int mode, input int exp_len, input bit retrig);
    int  n;
    bit  f;
    bit  kicked;
    busy_cnt[d] = 0;
    for (int r = 0; r < (retrig ? 2 : 1); r++) begin
      step(d, 1'b1);
      n      = 0;
      kicked = 1'b0;
      while (m_active[d] && n < 5000) begin
        f = pick_flick(d, mode, kicked);
        if (f) kicked = 1'b1;
        step(d, f);
        n++;
      end
      if (n >= 5000) begin
        checks++;
        errors++;
        $display("FAIL timeout dut %0d mode %0d", d, mode);
      end
    end
    step(d, 1'b0);
    step(d, 1'b0);
    if (exp_len > 0) check($sformatf("run_len_dut%0d", d), busy_cnt[d], exp_len);
  endtask

  task automatic reset_mid_run();
    int n = 0;
    step(1, 1'b1);
    while (m_lvl[1] != 9 && n < 2000) begin
      step(1, 1'b0);
      n++;
    end
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_rst_level", int'(lvl_b), 0);
    check("async_rst_led", int'(led_b), 0);
    check("async_rst_busy", int'(busy_b), 0);
    model_reset(1);
    push_exp(1);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    run(1, 0, 248, 1'b0);
  endtask

  // Monitor: every cycle with a pending prediction, compare the addressed instance.
  initial begin
    exp_t e;
    int   al, aled, ab;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.d)
          0:       begin al = int'(lvl_a); aled = int'(led_a); ab = int'(busy_a); end
          1:       begin al = int'(lvl_b); aled = int'(led_b); ab = int'(busy_b); end
          default: begin al = int'(lvl_c); aled = int'(led_c); ab = int'(busy_c); end
        endcase
        if (ab != 0) busy_cnt[e.d]++;
        checks++;
        if (al != e.lvl || aled != ((1 << e.lvl) - 1) || ab != int'(e.busy)) begin
          errors++;
          $display("FAIL sb_dut%0d got level=%0d led=%0h busy=%0d want level=%0d led=%0h busy=%0d",
                   e.d, al, aled, ab, e.lvl, (1 << e.lvl) - 1, e.busy);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    flick_a = 1'b1; flick_b = 1'b1; flick_c = 1'b1;
    for (int d = 0; d < 3; d++) begin
      model_reset(d);
      busy_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_level_a", int'(lvl_a), 0);
    check("rst_led_a", int'(led_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_level_c", int'(lvl_c), 0);
    check("rst_busy_b", int'(busy_b), 0);
    @(negedge clk);
    flick_a = 1'b0; flick_b = 1'b0; flick_c = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    run(0, 0, 62, 1'b0);
    run(0, 1, 86, 1'b0);
    run(0, 2, 0, 1'b0);
    run(0, 3, 0, 1'b0);
    run(0, 4, 62, 1'b0);
    run(1, 0, 248, 1'b0);
    reset_mid_run();
    run(2, 0, 34, 1'b0);
    run(0, 0, 0, 1'b1);
    repeat (4) run(0, 5, 0, 1'b0);
    repeat (4) run(2, 5, 0, 1'b0);
    run(1, 5, 0, 1'b0);

    step(0, 1'b0);
    step(0, 1'b0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bound_flasher_gen.md
Name: bound_flasher_gen

Overview:
- Parametrised successor to the fixed 16-LED bound flasher: a thermometer-coded LED bar that sweeps through a six-phase up/down pattern after a `flick` request.
- Supports kickback, where `flick` at defined marks returns the sweep to the previous up phase.
- Generalised in LED count, turn-around marks and step rate (built-in prescaler).
- Adds `busy` and `level` status outputs for the top-level sequencer.

Parameters:
- N_LED, 16, number of LEDs (>=4).
- LO_MARK, 5, low turn-around level; also a kickback point (0 < LO_MARK < HI_MARK).
- HI_MARK, 11, high turn-around level of the second up sweep (HI_MARK < N_LED).
- END_MARK, 6, peak level of the final up sweep (0 < END_MARK <= N_LED).
- STEP_DIV, 1, clock cycles per step (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- flick, input, 1, start/kickback request, level-sampled on clk.
- LED, output, N_LED, thermometer bar: LED[i] = (i < level).
- level, output, LW = clog2(N_LED+1), number of lit LEDs.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, level=0, LED=0, busy=0, prescaler=0. `flick` is ignored while reset is low.
- States: IDLE, UP1 (target N_LED), DN1 (target LO_MARK), UP2 (target HI_MARK), DN2 (target 0), UP3 (target END_MARK), DN3 (target 0).
- IDLE: on a clk edge with flick=1, go to UP1, level=0, prescaler=0. Otherwise stay in IDLE.
- Prescaler: counts 0..STEP_DIV-1 while not IDLE. A tick occurs when the count equals STEP_DIV-1, after which the count wraps to 0. With STEP_DIV=1, every non-IDLE cycle is a tick.
- On each tick, in any non-IDLE state:
  - if level != target: level steps by ±1 toward the target.
  - if level == target: level holds for one step (dwell) and the state transitions.
- Transitions at the dwell tick:
  - UP1 -> DN1.
  - DN1 -> UP1 if flick=1, else UP2.
  - UP2 -> DN2.
  - DN2 -> UP2 if flick=1, else UP3.
  - UP3 -> DN3.
  - DN3 -> IDLE.
- Extra kickback: in DN2, a tick with level==LO_MARK and flick=1 dwells there and goes to UP2. With flick=0 the sweep passes through without dwelling.
- Ignored flick: in UP1, UP2, UP3 and DN3, and at non-mark levels of DN1/DN2.
- Run length: with no kickbacks and default parameters, a run is 62 ticks from the start edge to IDLE.
- Re-trigger: if flick is still 1 on the first IDLE cycle after DN3, a new run starts on the next edge.
- Mid-run reset: immediate return to IDLE, level=0 (asynchronous).
- Arithmetic: level is unsigned LW bits and never under- or overflows, because targets lie within 0..N_LED.
- Parameter violations: an elaboration-time assertion fires.

Decomposition:
- bound_flasher_pkg holds:
  - the state enum (IDLE, UP1, DN1, UP2, DN2, UP3, DN3);
  - a function target_of(state) returning the mark for each state;
  - a function is_kick_state(state).
- One sub-module, step_prescaler (STEP_DIV, clear, enable -> tick). All other logic stays in bound_flasher_gen.

Test Plan:
- Default parameters, single 1-cycle flick pulse:
  - level 1..16 on the 16 cycles after the start edge;
  - dwell, then 15..5, dwell, up to 11, down to 0, up to 6, down to 0;
  - busy=1 for exactly 62 cycles; LED=16'h0000 at the end.
- Kickback at DN1: flick=1 on the DN1 dwell tick (level=5) -> state=UP1; level climbs 6..16 again; the full pattern then completes.
- Kickbacks in DN2:
  - flick=1 at level 5 -> dwells at 5, returns to UP2, climbs to 11;
  - flick=1 at level 0 -> same return to UP2.
- Flick ignored outside marks: flick=1 during UP1 (level 8) and DN3 (level 3) -> run length unchanged at 62.
- Prescaler and reset:
  - STEP_DIV=4 -> level changes every 4th cycle; run length 248 cycles.
  - reset=0 at level 9 -> LED=0 and busy=0 immediately.
  - after release, flick restarts the run from level 0.
- Alternate parameters N_LED=8, LO_MARK=2, HI_MARK=5, END_MARK=3:
  - pattern 0..8 ->2 ->5 ->0 ->3 ->0;
  - run length 8+1+6+1+3+1+5+1+3+1+3+1 = 34 ticks.
